// File: rtl/operand_read_unit_if.sv
// operand_read_unit_if: decode, register-file, writeback and execute signals of the operand-read stage
interface operand_read_unit_if #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int RW   = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [RW-1:0]   in_rs1;
  logic [RW-1:0]   in_rs2;
  logic [RW-1:0]   in_rd;
  logic            in_use_rs1;
  logic            in_use_rs2;
  logic            in_iswb;
  logic            in_isld;
  logic            flush;
  logic [RW-1:0]   rf_raddr1;
  logic [RW-1:0]   rf_raddr2;
  logic [DW-1:0]   rf_rdata1;
  logic [DW-1:0]   rf_rdata2;
  logic            wb_en;
  logic [RW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_op;
  logic [RW-1:0]   out_rd;
  logic            out_iswb;
  logic            out_isld;
  logic [DW-1:0]   out_a;
  logic [DW-1:0]   out_b;
  logic [NREG-1:0] busy;
  logic [15:0]     stall_count;
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_iswb, in_isld,
    input  flush, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, out_valid, out_op, out_rd, out_iswb, out_isld,
    output out_a, out_b, busy, stall_count
  );
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_iswb, in_isld,
    output flush, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_op, out_rd, out_iswb, out_isld,
    input  out_a, out_b, busy, stall_count
  );
endinterface

// File: rtl/operand_read_unit.sv
// operand_read_unit: scoreboarded operand read with writeback forwarding and valid/ready issue
module operand_read_unit #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int RW   = 3
) (
  input logic clk,
  input logic rst,
  operand_read_unit_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, WAIT, ISSUE} state_t;
  state_t state;
  logic [RW-1:0] rs1, rs2;
  logic p1, p2, prd;
  logic accept, issue;
  logic [NREG-1:0] wb_mask, iss_mask, eff_busy;
  logic hz1, hz2, hzd, wb1, wb2, wbd, n1, n2, nd;
  logic [DW-1:0] v1, v2;
  assign bus.in_ready  = state == EMPTY || (state == ISSUE && bus.out_ready);
  assign bus.out_valid = state == ISSUE;
  // Sources are taken from decode whenever a new instruction can be accepted, so back-to-back issue reads the right registers.
  assign bus.rf_raddr1 = bus.in_ready ? bus.in_rs1 : rs1;
  assign bus.rf_raddr2 = bus.in_ready ? bus.in_rs2 : rs2;
  assign accept   = bus.in_valid && bus.in_ready && !bus.flush;
  assign issue    = state == ISSUE && bus.out_ready && !bus.flush;
  assign wb_mask  = bus.wb_en ? NREG'(1) << bus.wb_rd : '0;
  assign iss_mask = issue && bus.out_iswb ? NREG'(1) << bus.out_rd : '0;
  assign eff_busy = (bus.busy & ~wb_mask) | iss_mask;
  assign hz1 = bus.in_use_rs1 && eff_busy[bus.in_rs1];
  assign hz2 = bus.in_use_rs2 && eff_busy[bus.in_rs2];
  assign hzd = bus.in_iswb && eff_busy[bus.in_rd];
  assign v1 = !bus.in_use_rs1 || hz1 ? '0 : bus.wb_en && bus.wb_rd == bus.in_rs1 ? bus.wb_data : bus.rf_rdata1;
  assign v2 = !bus.in_use_rs2 || hz2 ? '0 : bus.wb_en && bus.wb_rd == bus.in_rs2 ? bus.wb_data : bus.rf_rdata2;
  assign wb1 = bus.wb_en && bus.wb_rd == rs1;
  assign wb2 = bus.wb_en && bus.wb_rd == rs2;
  assign wbd = bus.wb_en && bus.wb_rd == bus.out_rd;
  assign n1 = p1 && !wb1;
  assign n2 = p2 && !wb2;
  assign nd = prd && !wbd;
  // State machine, scoreboard, stall counter and the held instruction; flush overrides accept and issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= EMPTY;
      rs1             <= '0;
      rs2             <= '0;
      p1              <= 1'b0;
      p2              <= 1'b0;
      prd             <= 1'b0;
      bus.out_op      <= '0;
      bus.out_rd      <= '0;
      bus.out_iswb    <= 1'b0;
      bus.out_isld    <= 1'b0;
      bus.out_a       <= '0;
      bus.out_b       <= '0;
      bus.busy        <= '0;
      bus.stall_count <= '0;
    end else begin
      bus.busy <= eff_busy;
      if (state == WAIT && bus.stall_count != 16'hFFFF) bus.stall_count <= bus.stall_count + 16'd1;
      if (bus.flush) begin
        state <= EMPTY;
      end else if (accept) begin
        state        <= hz1 || hz2 || hzd ? WAIT : ISSUE;
        rs1          <= bus.in_rs1;
        rs2          <= bus.in_rs2;
        p1           <= hz1;
        p2           <= hz2;
        prd          <= hzd;
        bus.out_op   <= bus.in_op;
        bus.out_rd   <= bus.in_rd;
        bus.out_iswb <= bus.in_iswb;
        bus.out_isld <= bus.in_isld;
        bus.out_a    <= v1;
        bus.out_b    <= v2;
      end else if (state == WAIT) begin
        if (p1 && wb1) bus.out_a <= bus.wb_data;
        if (p2 && wb2) bus.out_b <= bus.wb_data;
        p1  <= n1;
        p2  <= n2;
        prd <= nd;
        if (!(n1 || n2 || nd)) state <= ISSUE;
      end else if (issue) begin
        state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_operand_read_unit.sv
// tb_operand_read_unit: directed checks of operand read, hazards, bypass, flush, reset and stall saturation
module tb_operand_read_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] rf [8];
  operand_read_unit_if #(.DW(16), .NREG(8), .RW(3)) bus ();
  operand_read_unit #(.DW(16), .NREG(8), .RW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic offer(input logic [3:0] op, input logic [2:0] r1, input logic u1,
                       input logic [2:0] r2, input logic u2, input logic [2:0] rd, input logic wb);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = r1;
    bus.in_use_rs1 = u1;
    bus.in_rs2     = r2;
    bus.in_use_rs2 = u2;
    bus.in_rd      = rd;
    bus.in_iswb    = wb;
    bus.in_isld    = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[1] = 16'hABCD;
    rf[2] = 16'h1234;
    bus.in_valid = 0; bus.in_op = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.in_use_rs1 = 0; bus.in_use_rs2 = 0; bus.in_iswb = 0; bus.in_isld = 0;
    bus.flush = 0; bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.out_ready = 0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 8'h00);
    chk("rst_out_a", bus.out_a, 0);
    chk("rst_out_b", bus.out_b, 0);
    chk("rst_stall", bus.stall_count, 0);
    chk("rst_out_op", bus.out_op, 0);
    // independent instruction
    offer(4'h3, 3'd1, 1, 3'd2, 1, 3'd3, 1);
    #1;
    chk("ind_raddr1", bus.rf_raddr1, 1);
    step();
    bus.in_valid = 0;
    chk("ind_out_valid", bus.out_valid, 1);
    chk("ind_out_a", bus.out_a, 16'hABCD);
    chk("ind_out_b", bus.out_b, 16'h1234);
    chk("ind_out_rd", bus.out_rd, 3);
    chk("ind_out_op", bus.out_op, 4'h3);
    chk("ind_in_ready_hold", bus.in_ready, 0);
    bus.out_ready = 1;
    #1;
    chk("ind_in_ready_hs", bus.in_ready, 1);
    step();
    bus.out_ready = 0;
    chk("ind_done_valid", bus.out_valid, 0);
    chk("ind_busy", bus.busy, 8'h08);
    // RAW stall on r2
    offer(4'h1, 3'd0, 0, 3'd0, 0, 3'd2, 1);
    step();
    bus.in_valid = 0;
    chk("prod_out_a_unused", bus.out_a, 0);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("prod_busy", bus.busy, 8'h0C);
    offer(4'h2, 3'd2, 1, 3'd0, 0, 3'd6, 1);
    step();
    bus.in_valid = 0;
    chk("raw_wait_valid", bus.out_valid, 0);
    chk("raw_wait_ready", bus.in_ready, 0);
    chk("raw_wait_raddr", bus.rf_raddr1, 2);
    step(); step();
    chk("raw_stall2", bus.stall_count, 2);
    bus.wb_en = 1; bus.wb_rd = 3'd2; bus.wb_data = 16'h5678;
    step();
    bus.wb_en = 0;
    chk("raw_valid", bus.out_valid, 1);
    chk("raw_out_a", bus.out_a, 16'h5678);
    chk("raw_busy", bus.busy, 8'h08);
    chk("raw_stall3", bus.stall_count, 3);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("raw_issue_busy", bus.busy, 8'h48);
    // same-cycle bypass on r4
    offer(4'h4, 3'd0, 0, 3'd0, 0, 3'd4, 1);
    step();
    bus.in_valid = 0;
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("byp_prod_busy", bus.busy, 8'h58);
    offer(4'h5, 3'd0, 0, 3'd4, 1, 3'd7, 0);
    bus.wb_en = 1; bus.wb_rd = 3'd4; bus.wb_data = 16'h00FF;
    step();
    bus.in_valid = 0;
    bus.wb_en = 0;
    chk("byp_valid", bus.out_valid, 1);
    chk("byp_out_b", bus.out_b, 16'h00FF);
    chk("byp_out_a", bus.out_a, 0);
    chk("byp_busy", bus.busy, 8'h48);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("byp_nowb_busy", bus.busy, 8'h48);
    // producer issues while dependent consumer is accepted
    offer(4'h6, 3'd0, 0, 3'd0, 0, 3'd5, 1);
    step();
    bus.out_ready = 1;
    offer(4'h7, 3'd5, 1, 3'd0, 0, 3'd1, 1);
    step();
    bus.in_valid = 0;
    bus.out_ready = 0;
    chk("b2b_wait_valid", bus.out_valid, 0);
    chk("b2b_busy", bus.busy, 8'h68);
    chk("b2b_in_ready", bus.in_ready, 0);
    // flush mid-WAIT
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_busy", bus.busy, 8'h68);
    chk("flush_stall", bus.stall_count, 4);
    // reset during ISSUE
    offer(4'h8, 3'd1, 1, 3'd2, 1, 3'd0, 1);
    step();
    bus.in_valid = 0;
    chk("iss_out_a", bus.out_a, 16'hABCD);
    chk("iss_valid", bus.out_valid, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst2_valid", bus.out_valid, 0);
    chk("rst2_out_a", bus.out_a, 0);
    chk("rst2_busy", bus.busy, 8'h00);
    chk("rst2_stall", bus.stall_count, 0);
    chk("rst2_in_ready", bus.in_ready, 1);
    // stall counter saturation
    offer(4'h9, 3'd0, 0, 3'd0, 0, 3'd3, 1);
    step();
    bus.in_valid = 0;
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    offer(4'hA, 3'd3, 1, 3'd0, 0, 3'd0, 0);
    step();
    bus.in_valid = 0;
    chk("sat_start", bus.stall_count, 0);
    repeat (65540) step();
    chk("sat_stall", bus.stall_count, 16'hFFFF);
    chk("sat_valid", bus.out_valid, 0);
    bus.wb_en = 1; bus.wb_rd = 3'd3; bus.wb_data = 16'hBEEF;
    step();
    bus.wb_en = 0;
    chk("sat_exit_valid", bus.out_valid, 1);
    chk("sat_exit_a", bus.out_a, 16'hBEEF);
    chk("sat_hold", bus.stall_count, 16'hFFFF);
    chk("sat_busy", bus.busy, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
